// File: rtl/spiart_spi_if.sv
// -----------------------------------------------------------------------------
// spiart_spi_if
// Bundles the command-side request/response signals and the SPI pins of the
// byte-wide SPI master.
//   master modport : upstream command logic plus the external pin side.
//                    Drives cpol/cpha/divparam/spi_tx/spi_start and miso.
//                    Observes spi_busy/spi_rx/sclk/mosi.
//   slave modport  : the SPI master itself (spiart_spi).
// -----------------------------------------------------------------------------
interface spiart_spi_if;
  logic       cpol;
  logic       cpha;
  logic [7:0] divparam;
  logic [7:0] spi_tx;
  logic       spi_start;
  logic       spi_busy;
  logic [7:0] spi_rx;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    output cpol, cpha, divparam, spi_tx, spi_start, miso,
    input  spi_busy, spi_rx, sclk, mosi
  );

  modport slave (
    input  cpol, cpha, divparam, spi_tx, spi_start, miso,
    output spi_busy, spi_rx, sclk, mosi
  );
endinterface

// File: rtl/spiart_spi.sv
// -----------------------------------------------------------------------------
// spiart_spi
// Byte-wide SPI master executing single-byte transfers for the SPI-UART bridge.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : spiart_spi_if.slave
//           in  cpol, cpha, divparam[7:0], spi_tx[7:0], spi_start, miso
//           out spi_busy, spi_rx[7:0], sclk, mosi
// A transfer is 16 SCLK edge events plus one trailing half-period, so busy
// lasts exactly 17*D clk cycles (D = divparam, with 0 treated as 1).
// Build option:
//   SPIART_SPI_MISO_SYNC_EN defined   -> MISO passes a 2-flop synchronizer.
//   SPIART_SPI_MISO_SYNC_EN undefined -> MISO sampled directly at the event.
// -----------------------------------------------------------------------------
module spiart_spi (
  input  logic         clk,
  input  logic         reset,
  spiart_spi_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] div_q, div_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_q, rx_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;

  logic [7:0] div_eff_s;
  logic [4:0] edge_inc_s;
  logic       lead_s;
  logic       miso_s;

  // A zero divider would stall the counter, so it behaves as 1.
  assign div_eff_s  = (bus.divparam == 8'd0) ? 8'd1 : bus.divparam;
  assign edge_inc_s = edge_q + 5'd1;
  // Odd-numbered events are leading SCLK edges.
  assign lead_s     = edge_inc_s[0];

`ifdef SPIART_SPI_MISO_SYNC_EN
  logic miso_meta_q;
  logic miso_sync_q;

  // Two-flop synchronizer for the asynchronous MISO pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= bus.miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign miso_s = miso_sync_q;
`else
  assign miso_s = bus.miso;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 5'd0;
      shift_q <= 8'h00;
      div_q   <= 8'd1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      busy_q  <= 1'b0;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      busy_q  <= busy_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  // Next-state and output logic of the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    busy_d  = busy_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    case (state_q)
      IDLE: begin
        sclk_d = bus.cpol;
        if (bus.spi_start) begin
          shift_d = bus.spi_tx;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          div_d   = div_eff_s;
          cnt_d   = div_eff_s;
          edge_d  = 5'd0;
          busy_d  = 1'b1;
          state_d = RUN;
          // Mode 0/2 must present the MSB before the first (sampling) edge.
          if (!bus.cpha) begin
            mosi_d = bus.spi_tx[7];
          end else begin
            mosi_d = mosi_q;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      RUN: begin
        if (cnt_q <= 8'd1) begin
          cnt_d  = div_q;
          edge_d = edge_inc_s;
          sclk_d = ~sclk_q;
          if (!cpha_q) begin
            if (lead_s) begin
              shift_d = {shift_q[6:0], miso_s};
            end else if (edge_inc_s != 5'd16) begin
              // Shift already moved the next bit to position 7 on the leading edge.
              mosi_d = shift_q[7];
            end else begin
              mosi_d = mosi_q;
            end
          end else begin
            if (lead_s) begin
              mosi_d = shift_q[7];
            end else begin
              shift_d = {shift_q[6:0], miso_s};
            end
          end
          // The reload above doubles as the timer for the trailing half-period.
          if (edge_inc_s == 5'd16) begin
            state_d = TAIL;
          end else begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      TAIL: begin
        sclk_d = cpol_q;
        if (cnt_q <= 8'd1) begin
          rx_d    = shift_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.spi_busy = busy_q;
  assign bus.spi_rx   = rx_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;

endmodule

// File: tb/tb_spiart_spi.sv
// -----------------------------------------------------------------------------
// tb_spiart_spi
// Scoreboard bench for spiart_spi (default build, MISO sampled directly).
// Stimulus pushes the expected transfer result when it raises spi_start; a
// negedge monitor measures each busy window (length, SCLK toggles, MOSI bits
// at the sampling edges, final SCLK, received byte) and compares.
// -----------------------------------------------------------------------------
module tb_spiart_spi;

  logic clk = 1'b0;
  logic reset;
  logic loop_en;
  logic miso_drv;
  int   n_checks = 0;
  int   n_errors = 0;

  spiart_spi_if bus ();

  assign bus.miso = loop_en ? bus.mosi : miso_drv;

  spiart_spi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cpol;
    logic       cpha;
    int         len;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t       cur;
  logic       have_cur  = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_sclk = 1'b0;
  int         busy_len  = 0;
  int         toggles   = 0;
  logic [7:0] mosi_byte = 8'h00;
  logic       lead;

  always @(negedge clk) begin
    if (reset) begin
      have_cur  = 1'b0;
      prev_busy = 1'b0;
      prev_sclk = bus.sclk;
    end else begin
      if (bus.spi_busy && !prev_busy) begin
        busy_len  = 0;
        toggles   = 0;
        mosi_byte = 8'h00;
        check("xfer_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (bus.spi_busy && have_cur) begin
        busy_len++;
        if (bus.sclk !== prev_sclk) begin
          toggles++;
          lead = (prev_sclk === cur.cpol);
          if (lead != cur.cpha) mosi_byte = {mosi_byte[6:0], bus.mosi};
        end
      end
      if (!bus.spi_busy && prev_busy && have_cur) begin
        check("busy_len", busy_len, cur.len);
        check("sclk_toggles", toggles, 16);
        check("mosi_bits", mosi_byte, cur.tx);
        check("sclk_final", bus.sclk, cur.cpol);
        check("spi_rx", bus.spi_rx, cur.rx);
        have_cur = 1'b0;
      end
      prev_busy = bus.spi_busy;
      prev_sclk = bus.sclk;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (bus.spi_busy === 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (bus.spi_busy === 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL busy_timeout: still busy after %0d cycles", max_cycles);
    end
  endtask

  task automatic xfer(input logic cpol, input logic cpha, input logic [7:0] div,
                      input logic [7:0] tx, input logic [7:0] rx, input int len,
                      input logic mid_change);
    exp_t e;
    @(posedge clk); #1;
    bus.cpol     = cpol;
    bus.cpha     = cpha;
    bus.divparam = div;
    bus.spi_tx   = tx;
    @(posedge clk); #1;
    e.cpol = cpol; e.cpha = cpha; e.len = len; e.tx = tx; e.rx = rx;
    exp_q.push_back(e);
    bus.spi_start = 1'b1;
    @(posedge clk); #1;
    bus.spi_start = 1'b0;
    check("busy_rise", bus.spi_busy, 1);
    if (mid_change) begin
      bus.divparam = 8'd8;
      bus.spi_tx   = ~tx;
      bus.cpha     = ~cpha;
    end
    wait_idle(5000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    reset         = 1'b1;
    loop_en       = 1'b0;
    miso_drv      = 1'b0;
    bus.cpol      = 1'b0;
    bus.cpha      = 1'b0;
    bus.divparam  = 8'd1;
    bus.spi_tx    = 8'h00;
    bus.spi_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, no start.
    @(negedge clk);
    check("rst_busy", bus.spi_busy, 0);
    check("rst_rx", bus.spi_rx, 8'h00);
    check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi, 0);

    // SCLK follows cpol one cycle later in IDLE.
    @(posedge clk); #1 bus.cpol = 1'b1;
    @(negedge clk);
    check("sclk_before_cpol", bus.sclk, 0);
    @(negedge clk);
    check("sclk_follow_hi", bus.sclk, 1);
    bus.cpol = 1'b0;
    @(negedge clk);
    check("sclk_follow_lo", bus.sclk, 0);

    // Mode 0, D=1, loopback.
    loop_en = 1'b1;
    xfer(1'b0, 1'b0, 8'd1, 8'hA5, 8'hA5, 17, 1'b0);

    // Mode 3, D=4, MISO high.
    loop_en  = 1'b0;
    miso_drv = 1'b1;
    xfer(1'b1, 1'b1, 8'd4, 8'h3C, 8'hFF, 68, 1'b0);

    // Divider 0 behaves as 1.
    miso_drv = 1'b0;
    xfer(1'b0, 1'b0, 8'd0, 8'h00, 8'h00, 17, 1'b0);

    // Mode 1, D=2, inputs changed mid-transfer.
    loop_en = 1'b1;
    xfer(1'b0, 1'b1, 8'd2, 8'h96, 8'h96, 34, 1'b1);

    // Back-to-back with spi_start held high.
    @(posedge clk); #1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.divparam = 8'd1; bus.spi_tx = 8'hC3;
    @(posedge clk); #1;
    e.cpol = 1'b0; e.cpha = 1'b0; e.len = 17; e.tx = 8'hC3; e.rx = 8'hC3;
    exp_q.push_back(e);
    e.tx = 8'h81; e.rx = 8'h81;
    exp_q.push_back(e);
    bus.spi_start = 1'b1;
    @(posedge clk); #1;
    bus.spi_tx = 8'h81;
    wait_idle(100);
    @(negedge clk);
    check("b2b_restart", bus.spi_busy, 1);
    bus.spi_start = 1'b0;
    wait_idle(100);

    // Reset at edge event 7, then a clean transfer.
    loop_en  = 1'b0;
    miso_drv = 1'b1;
    @(posedge clk); #1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.divparam = 8'd2; bus.spi_tx = 8'hFF;
    @(posedge clk); #1;
    e.cpol = 1'b0; e.cpha = 1'b0; e.len = 34; e.tx = 8'hFF; e.rx = 8'hFF;
    exp_q.push_back(e);
    bus.spi_start = 1'b1;
    @(posedge clk); #1;
    bus.spi_start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("ev7_busy", bus.spi_busy, 1);
    check("ev7_sclk", bus.sclk, 1);
    check("ev7_mosi", bus.mosi, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.spi_busy, 0);
    check("abort_sclk", bus.sclk, 0);
    check("abort_mosi", bus.mosi, 0);
    check("abort_rx", bus.spi_rx, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    loop_en = 1'b1;
    xfer(1'b0, 1'b0, 8'd2, 8'h69, 8'h69, 34, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
